// File: rtl/add_mul_result_acc_pkg.sv
// Shared types and defaults for the add/mul result frame accumulator.
`timescale 1ns/1ps
package add_mul_acc_pkg;

  // Accumulator FSM: ACC gathers samples, HOLD presents a finished frame.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W    = 8;
  localparam int DEFAULT_ACC_W     = 12;
  localparam int DEFAULT_FRAME_LEN = 4;

  // Width of the in-frame sample counter; covers 0..frame_len.
  function automatic int cnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/add_mul_result_acc_if.sv
// Handshake bundle for the result accumulator: sample stream in, frame
// results out. The master side drives samples and accepts results; the
// slave side is the accumulator itself.
// Optional: ADD_MUL_RESULT_ACC_MIN_EN adds the out_min frame minimum.
`timescale 1ns/1ps
interface add_mul_result_acc_if
  import add_mul_acc_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic              out_sat;
`ifdef ADD_MUL_RESULT_ACC_MIN_EN
  logic [DATA_W-1:0] out_min;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_sat
`ifdef ADD_MUL_RESULT_ACC_MIN_EN
    , input out_min
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_sat
`ifdef ADD_MUL_RESULT_ACC_MIN_EN
    , output out_min
`endif
  );

endinterface

// File: rtl/add_mul_result_acc_sat_add.sv
// Combinational saturating adder: unsigned ACC_W accumulator plus an
// unsigned DATA_W sample, clipped to the all-ones accumulator value.
`timescale 1ns/1ps
module sat_add #(
  parameter int ACC_W  = 12,
  parameter int DATA_W = 8
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  // Clip a one-bit-wider sum back to ACC_W bits, pinning at 2^ACC_W-1.
  function automatic logic [ACC_W-1:0] sat_clip(input logic [ACC_W:0] full);
    return full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  endfunction

  logic [ACC_W:0] full_sum;

  // One extra carry bit is enough because ACC_W > DATA_W.
  assign full_sum = {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, b};
  assign ovf      = full_sum[ACC_W];
  assign sum      = sat_clip(full_sum);

endmodule

// File: rtl/add_mul_result_acc.sv
// Frame accumulator for the add/mul Result stream. Collects FRAME_LEN
// unsigned samples, then presents the saturating sum, the maximum and a
// saturation flag until the downstream consumer takes them.
// Optional: define ADD_MUL_RESULT_ACC_MIN_EN to also report the frame minimum.
`timescale 1ns/1ps
module add_mul_result_acc
  import add_mul_acc_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ACC_W     = DEFAULT_ACC_W,
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
  input logic                 clk,
  input logic                 rst_n,
  add_mul_result_acc_if.slave bus
);

  localparam int               CNT_W    = cnt_w(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] max_r;
  logic              sat_r;

  logic              frame_valid;
  logic [ACC_W-1:0]  frame_sum;
  logic [DATA_W-1:0] frame_max;
  logic              frame_sat;

  logic [ACC_W-1:0]  sum_next;
  logic              ovf;
  logic [DATA_W-1:0] max_next;
  logic              sat_next;
  logic              first_beat;
  logic              last_beat;
  logic              accept;

`ifdef ADD_MUL_RESULT_ACC_MIN_EN
  logic [DATA_W-1:0] min_r;
  logic [DATA_W-1:0] frame_min;
  logic [DATA_W-1:0] min_next;
`endif

  sat_add #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_sat_add (
    .a   (acc),
    .b   (bus.in_data),
    .sum (sum_next),
    .ovf (ovf)
  );

  // The first beat of a frame seeds max/min instead of comparing with stale values.
  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == LAST_CNT);
  assign max_next   = (first_beat || (bus.in_data > max_r)) ? bus.in_data : max_r;
  assign sat_next   = sat_r | ovf;
  assign accept     = (state == ACC) && bus.in_valid;

`ifdef ADD_MUL_RESULT_ACC_MIN_EN
  assign min_next   = (first_beat || (bus.in_data < min_r)) ? bus.in_data : min_r;
`endif

  // Ready comes from the state register alone; it is held low during reset
  // so upstream never sees a spurious accept window while rst_n is asserted.
  assign bus.in_ready  = (state == ACC) && rst_n;
  assign bus.out_valid = frame_valid;
  assign bus.out_sum   = frame_sum;
  assign bus.out_max   = frame_max;
  assign bus.out_sat   = frame_sat;
`ifdef ADD_MUL_RESULT_ACC_MIN_EN
  assign bus.out_min   = frame_min;
`endif

  // FSM plus frame accumulation and result registers; reset discards any
  // partial or pending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      max_r       <= '0;
      sat_r       <= 1'b0;
      frame_valid <= 1'b0;
      frame_sum   <= '0;
      frame_max   <= '0;
      frame_sat   <= 1'b0;
`ifdef ADD_MUL_RESULT_ACC_MIN_EN
      min_r       <= '0;
      frame_min   <= '0;
`endif
    end else if (state == ACC) begin
      if (accept) begin
        if (last_beat) begin
          // Final sample: publish results that include this beat and
          // restart the running state for the next frame.
          frame_sum   <= sum_next;
          frame_max   <= max_next;
          frame_sat   <= sat_next;
          frame_valid <= 1'b1;
          state       <= HOLD;
          acc         <= '0;
          cnt         <= '0;
          max_r       <= '0;
          sat_r       <= 1'b0;
`ifdef ADD_MUL_RESULT_ACC_MIN_EN
          frame_min   <= min_next;
          min_r       <= '0;
`endif
        end else begin
          acc   <= sum_next;
          cnt   <= cnt + CNT_W'(1);
          max_r <= max_next;
          sat_r <= sat_next;
`ifdef ADD_MUL_RESULT_ACC_MIN_EN
          min_r <= min_next;
`endif
        end
      end
    end else begin
      // HOLD: results stay put until taken; data registers keep their
      // values after the handshake.
      if (bus.out_ready) begin
        frame_valid <= 1'b0;
        state       <= ACC;
      end
    end
  end

endmodule
